// File: rtl/multichannel_and_latch_pkg.sv
// Shared definitions for the multichannel AND-latch mux: the selector mode encoding.
package multichannel_and_latch_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_DIRECT = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

endpackage

// File: rtl/and_latch_lane.sv
// One lane: enabled register of a & b, plus a flag recording that it was loaded since reset.
module and_latch_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] lat,
  output logic             loaded
);

  logic [WIDTH-1:0] r_lat;
  logic             r_loaded;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_lat    <= '0;
      r_loaded <= 1'b0;
    end else if (load_en) begin
      r_lat    <= a_in & b_in;
      r_loaded <= 1'b1;
    end
  end

  assign lat    = r_lat;
  assign loaded = r_loaded;

endmodule

// File: rtl/multichannel_and_latch_mux.sv
// NUM_CHANNELS AND-latch lanes feeding a registered output through a rotate/hold/direct selector.
module multichannel_and_latch_mux
  import multichannel_and_latch_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int WIDTH        = 8,
  parameter  int SEL_DIV      = 1,
  localparam int SEL_W        = $clog2(NUM_CHANNELS)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_CHANNELS*WIDTH-1:0] a_in,
  input  logic [NUM_CHANNELS*WIDTH-1:0] b_in,
  input  logic [NUM_CHANNELS-1:0]       load_en,
  input  logic [1:0]                    mode,
  input  logic [SEL_W-1:0]              sel_in,
  output logic [WIDTH-1:0]              out,
  output logic [SEL_W-1:0]              out_sel,
  output logic                          out_valid,
  output logic                          wrap
);

  localparam int                DIV_W     = (SEL_DIV > 1) ? $clog2(SEL_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SEL_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CHANNELS - 1);
  localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NUM_CHANNELS);

  logic [WIDTH-1:0]        w_lat [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_loaded;
  logic [WIDTH-1:0]        w_sel_lat;
  logic                    w_sel_loaded;
  mode_e                   w_mode;
  logic [SEL_W-1:0]        w_sel_d;
  logic [DIV_W-1:0]        w_div_d;
  logic                    w_wrap_d;

  logic [SEL_W-1:0]        r_sel_q;
  logic [DIV_W-1:0]        r_div_q;
  logic [WIDTH-1:0]        r_out;
  logic [SEL_W-1:0]        r_out_sel;
  logic                    r_out_valid;
  logic                    r_wrap;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    and_latch_lane #(.WIDTH(WIDTH)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .load_en (load_en[i]),
      .a_in    (a_in[i*WIDTH +: WIDTH]),
      .b_in    (b_in[i*WIDTH +: WIDTH]),
      .lat     (w_lat[i]),
      .loaded  (w_loaded[i])
    );
  end

  // Compare-based mux so a non-power-of-two lane count never indexes past the array.
  always_comb begin
    w_sel_lat    = '0;
    w_sel_loaded = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_sel_q == SEL_W'(i)) begin
        w_sel_lat    = w_lat[i];
        w_sel_loaded = w_loaded[i];
      end
    end
  end

  assign w_mode = mode_e'(mode);

  always_comb begin
    w_sel_d  = r_sel_q;
    w_div_d  = r_div_q;
    w_wrap_d = 1'b0;
    case (w_mode)
      MODE_ROTATE: begin
        if (r_div_q == DIV_LAST) begin
          w_div_d = '0;
          if (r_sel_q == SEL_LAST) begin
            w_sel_d  = '0;
            w_wrap_d = 1'b1;
          end else begin
            w_sel_d = r_sel_q + SEL_W'(1);
          end
        end else begin
          w_div_d = r_div_q + DIV_W'(1);
        end
      end
      MODE_DIRECT: begin
        w_div_d = '0;
        // Out-of-range indices are dropped rather than clamped.
        if ({1'b0, sel_in} < SEL_LIMIT) w_sel_d = sel_in;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sel_q     <= '0;
      r_div_q     <= '0;
      r_out       <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_sel_q     <= w_sel_d;
      r_div_q     <= w_div_d;
      r_out       <= w_sel_lat;
      r_out_sel   <= r_sel_q;
      r_out_valid <= w_sel_loaded;
      r_wrap      <= w_wrap_d;
    end
  end

  assign out       = r_out;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;
  assign wrap      = r_wrap;

endmodule
